// File: rtl/sdram_cmd_arbiter.sv
// SDRAM command bus owner: init passthrough, then periodic auto-refresh with debt tracking
// and a single granted access requester. All outputs registered. Optional RefCnt via SDRAM_REFCNT_EN.
module sdram_cmd_arbiter #(
    parameter int SDRAMMHZ     = 100,
    parameter int REFPERIOD_NS = 7800,
    parameter int CYCNUMRP     = 2,
    parameter int CYCNUMRFC    = 7,
    parameter int REFDEBT      = 4
) (
    input  logic        Clk,
    input  logic        Rest,
    input  logic [3:0]  InitCmd,
    input  logic [12:0] InitMode,
    input  logic        InitDone,
    input  logic        ReInit,
    input  logic        AccReq,
    input  logic [3:0]  AccCmd,
    input  logic [12:0] AccAddr,
    input  logic [1:0]  AccBa,
    input  logic        AccDone,
    output logic        AccGnt,
    output logic        AccUrgent,
    output logic [3:0]  SdramCmd,
    output logic [12:0] SdramAddr,
    output logic [1:0]  SdramBa
`ifdef SDRAM_REFCNT_EN
    ,
    output logic [15:0] RefCnt
`endif
);

    localparam int REFCYC = REFPERIOD_NS * SDRAMMHZ / 1000;
    localparam int TMR_W  = (REFCYC > 1) ? $clog2(REFCYC) : 1;
    localparam int DEBT_W = $clog2(REFDEBT + 1);
    localparam int PH_MAX = (CYCNUMRP > CYCNUMRFC) ? CYCNUMRP : CYCNUMRFC;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_REF_PRE,
        S_REF_AR,
        S_ACCESS
    } state_t;

    state_t              state, state_nxt;
    logic [TMR_W-1:0]    timer;
    logic [DEBT_W-1:0]   debt, debt_nxt;
    logic [PH_W-1:0]     phase, phase_nxt;
    logic                wrap, ref_pend, ref_done, ar_issue;
    logic [3:0]          cmd_nxt;
    logic [12:0]         addr_nxt;
    logic [1:0]          ba_nxt;
    logic                gnt_nxt;

    assign wrap     = (state != S_INIT) && (timer == TMR_W'(REFCYC - 1));
    // A wrap this cycle already counts as owed, so a simultaneous AccReq loses to it.
    assign ref_pend = (debt != '0) || wrap;

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        cmd_nxt   = CMD_NOP;
        addr_nxt  = '0;
        ba_nxt    = '0;
        gnt_nxt   = 1'b0;
        ref_done  = 1'b0;
        ar_issue  = 1'b0;
        case (state)
            S_INIT: begin
                cmd_nxt  = InitCmd;
                addr_nxt = InitMode;
                if (InitDone) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (ReInit) begin
                    state_nxt = S_INIT;
                end else if (ref_pend) begin
                    state_nxt = S_REF_PRE;
                    phase_nxt = '0;
                    cmd_nxt   = CMD_PRE;
                    addr_nxt  = 13'h0400;
                end else if (AccReq) begin
                    state_nxt = S_ACCESS;
                    gnt_nxt   = 1'b1;
                end
            end
            S_REF_PRE: begin
                if (phase == PH_W'(CYCNUMRP - 1)) begin
                    state_nxt = S_REF_AR;
                    phase_nxt = '0;
                    cmd_nxt   = CMD_AREF;
                    ar_issue  = 1'b1;
                end else begin
                    phase_nxt = phase + 1'b1;
                end
            end
            S_REF_AR: begin
                if (phase == PH_W'(CYCNUMRFC - 1)) begin
                    state_nxt = S_IDLE;
                    ref_done  = 1'b1;
                end else begin
                    phase_nxt = phase + 1'b1;
                end
            end
            S_ACCESS: begin
                if (AccDone) begin
                    state_nxt = S_IDLE;
                end else begin
                    gnt_nxt  = 1'b1;
                    cmd_nxt  = AccCmd;
                    addr_nxt = AccAddr;
                    ba_nxt   = AccBa;
                end
            end
            default: state_nxt = S_INIT;
        endcase
    end

    // Wrap and completion in the same cycle cancel out, even when saturated.
    always_comb begin
        debt_nxt = debt;
        if (wrap && !ref_done) begin
            if (debt != DEBT_W'(REFDEBT)) debt_nxt = debt + 1'b1;
        end else if (ref_done && !wrap) begin
            debt_nxt = debt - 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rest) begin
            state     <= S_INIT;
            phase     <= '0;
            timer     <= '0;
            debt      <= '0;
            SdramCmd  <= CMD_NOP;
            SdramAddr <= '0;
            SdramBa   <= '0;
            AccGnt    <= 1'b0;
            AccUrgent <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase     <= phase_nxt;
            debt      <= debt_nxt;
            SdramCmd  <= cmd_nxt;
            SdramAddr <= addr_nxt;
            SdramBa   <= ba_nxt;
            AccGnt    <= gnt_nxt;
            AccUrgent <= (debt_nxt == DEBT_W'(REFDEBT));
            if (state == S_INIT || wrap) timer <= '0;
            else                         timer <= timer + 1'b1;
        end
    end

`ifdef SDRAM_REFCNT_EN
    always_ff @(posedge Clk) begin
        if (Rest || (state == S_IDLE && ReInit)) RefCnt <= '0;
        else if (ar_issue)                      RefCnt <= RefCnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Directed bench for sdram_cmd_arbiter: boot, periodic refresh, contention, long access,
// pass-through, mid-refresh reset and ReInit priority, with hand-derived cycle numbers.
module tb_sdram_cmd_arbiter;

    logic        Clk = 1'b0;
    logic        Rest;
    logic [3:0]  InitCmd;
    logic [12:0] InitMode;
    logic        InitDone, ReInit, AccReq, AccDone;
    logic [3:0]  AccCmd;
    logic [12:0] AccAddr;
    logic [1:0]  AccBa;
    logic        AccGnt, AccUrgent;
    logic [3:0]  SdramCmd;
    logic [12:0] SdramAddr;
    logic [1:0]  SdramBa;
`ifdef SDRAM_REFCNT_EN
    logic [15:0] RefCnt;
`endif

    sdram_cmd_arbiter dut (
        .Clk(Clk), .Rest(Rest), .InitCmd(InitCmd), .InitMode(InitMode), .InitDone(InitDone),
        .ReInit(ReInit), .AccReq(AccReq), .AccCmd(AccCmd), .AccAddr(AccAddr), .AccBa(AccBa),
        .AccDone(AccDone), .AccGnt(AccGnt), .AccUrgent(AccUrgent), .SdramCmd(SdramCmd),
        .SdramAddr(SdramAddr), .SdramBa(SdramBa)
`ifdef SDRAM_REFCNT_EN
        , .RefCnt(RefCnt)
`endif
    );

    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    logic [3:0] ref_tbl [9];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    // Nine cycles starting at the PRECHARGE edge; grant must stay low throughout.
    task automatic ref_seq(input string tag);
        int errs = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            if (SdramCmd !== ref_tbl[i] || AccGnt !== 1'b0) errs++;
            if (i == 0) chk({tag, "_pre_addr"}, 32'(SdramAddr), 32'h0400);
        end
        chk({tag, "_seq"}, 32'(errs), 32'd0);
    endtask

    initial begin
        int bad, n_ar, n_pre, gnt_seen;
        ref_tbl[0] = 4'b0010; ref_tbl[1] = 4'b0111; ref_tbl[2] = 4'b0001;
        for (int i = 3; i < 9; i++) ref_tbl[i] = 4'b0111;

        Rest = 1; InitCmd = 4'b0111; InitMode = '0; InitDone = 0; ReInit = 0;
        AccReq = 0; AccCmd = 4'b0111; AccAddr = '0; AccBa = '0; AccDone = 0;
        step(); step();
        chk("rst_cmd", 32'(SdramCmd), 32'h7);
        chk("rst_addr", 32'(SdramAddr), 32'h0);
        chk("rst_gnt", 32'(AccGnt), 32'h0);
        chk("rst_urgent", 32'(AccUrgent), 32'h0);
        chk("rst_debt", 32'(dut.debt), 32'h0);
        Rest = 0;

        // Boot edge is cycle 0; the timer starts from 0 in the following IDLE cycle.
        InitCmd = 4'b0001; InitMode = 13'h0022; InitDone = 1;
        step();
        cyc = 0;
        chk("boot_cmd", 32'(SdramCmd), 32'h1);
        chk("boot_addr", 32'(SdramAddr), 32'h22);
        InitCmd = 4'b0111; InitMode = '0; InitDone = 0;
        bad = 0;
        for (int i = 1; i < 780; i++) begin
            step();
            if (SdramCmd !== 4'b0111) bad++;
        end
        chk("boot_quiet", 32'(bad), 32'd0);
        ref_seq("periodic");
        step();
        chk("periodic_idle_cmd", 32'(SdramCmd), 32'h7);
        chk("periodic_debt", 32'(dut.debt), 32'h0);

        // AccReq arrives on the very edge the timer wraps again (cycle 1560).
        run_to(1559);
        AccReq = 1;
        ref_seq("contention");
        step();
        chk("contention_gnt_low", 32'(AccGnt), 32'h0);
        step();
        chk("contention_gnt", 32'(AccGnt), 32'h1);

        AccCmd = 4'b0011; AccAddr = 13'h1ABC; AccBa = 2'd2;
        step();
        chk("pass_cmd", 32'(SdramCmd), 32'h3);
        chk("pass_addr", 32'(SdramAddr), 32'h1ABC);
        chk("pass_ba", 32'(SdramBa), 32'h2);
        AccDone = 1;
        step();
        chk("release_gnt", 32'(AccGnt), 32'h0);
        chk("release_cmd", 32'(SdramCmd), 32'h7);
        AccDone = 0;
        step();
        chk("regrant", 32'(AccGnt), 32'h1);

        // Wraps at 2340, 3120, 3900, 4680 saturate the debt; 5460 must not overflow it.
        run_to(4679);
        chk("urgent_pre", 32'(AccUrgent), 32'h0);
        step();
        chk("urgent_set", 32'(AccUrgent), 32'h1);
        chk("debt_sat", 32'(dut.debt), 32'h4);
        run_to(5460);
        chk("debt_sat_hold", 32'(dut.debt), 32'h4);
        chk("no_mid_access_ref", 32'(SdramCmd), 32'h3);
        run_to(5499);
        AccDone = 1;
        step();
        chk("long_release_gnt", 32'(AccGnt), 32'h0);
        AccDone = 0;
        n_ar = 0; n_pre = 0; gnt_seen = 0;
        while (cyc < 5540) begin
            step();
            if (SdramCmd === 4'b0001) n_ar++;
            if (SdramCmd === 4'b0010) n_pre++;
            if (AccGnt !== 1'b0) gnt_seen++;
        end
        chk("drain_autoref", 32'(n_ar), 32'd4);
        chk("drain_pre", 32'(n_pre), 32'd4);
        chk("drain_gnt_held", 32'(gnt_seen), 32'd0);
        chk("drain_urgent", 32'(AccUrgent), 32'h0);
        step();
        chk("drain_gnt", 32'(AccGnt), 32'h1);
        chk("drain_debt", 32'(dut.debt), 32'h0);
        AccDone = 1; AccReq = 0;
        step();
        AccDone = 0;

        run_to(6239);
        step();
        chk("third_ref_pre", 32'(SdramCmd), 32'h2);
        run_to(6244);
`ifdef SDRAM_REFCNT_EN
        chk("refcnt", 32'(RefCnt), 32'd7);
`endif
        Rest = 1;
        step();
        chk("midref_rst_cmd", 32'(SdramCmd), 32'h7);
        chk("midref_rst_gnt", 32'(AccGnt), 32'h0);
        chk("midref_rst_urgent", 32'(AccUrgent), 32'h0);
        chk("midref_rst_debt", 32'(dut.debt), 32'h0);
`ifdef SDRAM_REFCNT_EN
        chk("midref_rst_refcnt", 32'(RefCnt), 32'd0);
`endif
        Rest = 0; InitCmd = 4'b0010; InitMode = 13'h0155;
        step();
        chk("init_follow_cmd", 32'(SdramCmd), 32'h2);
        chk("init_follow_addr", 32'(SdramAddr), 32'h155);

        // ReInit beats a pending AccReq in IDLE.
        InitDone = 1; InitCmd = 4'b0111; InitMode = '0;
        step();
        InitDone = 0; ReInit = 1; AccReq = 1; InitCmd = 4'b0000; InitMode = 13'h00AA;
        step();
        ReInit = 0;
        step();
        chk("reinit_cmd", 32'(SdramCmd), 32'h0);
        chk("reinit_addr", 32'(SdramAddr), 32'hAA);
        chk("reinit_gnt", 32'(AccGnt), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sdram_cmd_arbiter.md
Name: sdram_cmd_arbiter

Overview:
- Owns the SDRAM command/address bus after power-up.
- Shares the bus between three sources:
  - the init sequencer's command stream, until its done pulse;
  - an internal periodic auto-refresh scheduler;
  - one external read/write access requester.
- Sits between the init sequencer / access engine and the SDRAM pin registers. All outputs are registered.

Parameters:
- SDRAMMHZ, 100, clock frequency in MHz.
- REFPERIOD_NS, 7800, average refresh interval in ns. REFCYC = REFPERIOD_NS*SDRAMMHZ/1000 (780 at defaults).
- CYCNUMRP, 2, tRP in cycles: precharge-to-next-command spacing.
- CYCNUMRFC, 7, tRFC in cycles: autorefresh-to-next-command spacing.
- REFDEBT, 4, maximum number of postponed refreshes held before saturation.

Ports:
- Clk  in  1  system clock.
- Rest  in  1  reset. Synchronous, active-high.
- InitCmd  in  4  command from the init sequencer.
- InitMode  in  13  address/mode from the init sequencer.
- InitDone  in  1  one-cycle pulse: init sequence complete.
- ReInit  in  1  re-initialisation request. Level, sampled in IDLE.
- AccReq  in  1  access requester wants the bus.
- AccCmd  in  4  access command.
- AccAddr  in  13  access address.
- AccBa  in  2  access bank.
- AccDone  in  1  access requester releases the bus this cycle.
- AccGnt  out  1  bus granted to the access requester.
- AccUrgent  out  1  refresh debt is saturated; requester must release the bus.
- SdramCmd  out  4  {CS,RAS,CAS,WE}.
- SdramAddr  out  13  SDRAM address.
- SdramBa  out  2  SDRAM bank.

Behaviour:
- Command encodings:
  - NOP = 4'b0111
  - PRECHARGE = 4'b0010
  - AUTOREF = 4'b0001
- Reset (Rest=1 at posedge) applies in any state, including mid-refresh and mid-access. Values next cycle:
  - state INIT;
  - SdramCmd = NOP, SdramAddr = 0, SdramBa = 0;
  - AccGnt = 0, AccUrgent = 0;
  - refresh timer = 0, debt = 0, phase counter = 0.
- State INIT:
  - Outputs follow InitCmd/InitMode one cycle later; SdramBa = 0.
  - Refresh timer is held at 0.
  - When InitDone = 1, go to IDLE. Timer starts at 0 on the next cycle.
- Refresh timer (every state except INIT):
  - Counts 0..REFCYC-1, then wraps.
  - On each wrap, debt increments, saturating at REFDEBT.
  - If a wrap and a refresh completion happen in the same cycle, debt is unchanged.
- AccUrgent = 1 whenever debt == REFDEBT. It is registered.
- State IDLE (outputs NOP):
  - If ReInit = 1, go to INIT. This has highest priority.
  - Else if debt > 0, go to REF_PRE. Refresh beats access.
  - Else if AccReq = 1, go to ACCESS and set AccGnt = 1 on the same edge.
- State REF_PRE:
  - First cycle: SdramCmd = PRECHARGE, SdramAddr = 13'h0400 (A10 = all banks).
  - Then NOP until CYCNUMRP cycles have elapsed since the PRECHARGE.
  - Then go to REF_AR.
- State REF_AR:
  - First cycle: SdramCmd = AUTOREF.
  - Then NOP until CYCNUMRFC cycles have elapsed.
  - Then decrement debt and go to IDLE.
  - Total refresh occupancy is CYCNUMRP + CYCNUMRFC cycles.
- State ACCESS:
  - SdramCmd/SdramAddr/SdramBa = AccCmd/AccAddr/AccBa, registered (1-cycle latency).
  - On AccDone = 1: AccGnt drops and the state returns to IDLE next cycle; the command output that cycle is NOP.
  - A refresh is never inserted mid-access.
  - If AccReq stays high after release, the grant is re-issued only from IDLE, after any pending refresh.
- ReInit outside IDLE is ignored. The requester holds it until it is serviced in IDLE.
- AccDone outside ACCESS is ignored.

Optional Feature:
- Macro: SDRAM_REFCNT_EN.
- Defined:
  - Adds output RefCnt [15:0], counting issued AUTOREF commands. It excludes the init sequencer's autorefreshes.
  - Wraps from 16'hFFFF to 0.
  - Cleared by Rest and on entry to INIT.
- Undefined: the port and its counter do not exist; all other behaviour is identical.

Test Plan:
- Boot: drive InitCmd = AUTOREF and InitMode = 13'h0022, pulse InitDone.
  -> SdramCmd = AUTOREF and SdramAddr = 13'h0022 one cycle later; IDLE follows; no refresh for 780 cycles.
- Periodic refresh, AccReq = 0, defaults: 780 cycles after InitDone
  -> PRECHARGE with SdramAddr = 13'h0400, NOP, AUTOREF, then NOP ×6.
- Contention: AccReq = 1 on the same cycle the timer wraps
  -> the refresh sequence is issued first; AccGnt rises only after the refresh returns to IDLE.
- Long access: hold a grant for 4000 cycles without AccDone
  -> AccUrgent = 1 after the 4th wrap and debt stays at 4. After AccDone, four back-to-back refresh sequences run, then AccUrgent = 0.
- Access pass-through: AccCmd = 4'b0011, AccAddr = 13'h1ABC, AccBa = 2
  -> the same values appear on SdramCmd/SdramAddr/SdramBa one cycle later; AccDone gives AccGnt = 0 and NOP next cycle.
- Reset mid-refresh: assert Rest during the AUTOREF wait
  -> state INIT, SdramCmd = NOP, debt = 0, AccGnt = 0 next cycle. With SDRAM_REFCNT_EN, RefCnt = 0.
